// File: rtl/regfile_sb.sv
// Register file with per-register pending (scoreboard) bits, optional
// write-to-read forwarding and a registered count of pending registers.
module regfile_sb #(
    parameter int  XLEN   = 32,
    parameter int  NREG   = 32,
    parameter int  BYPASS = 1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_ready,
    output logic            rs2_ready,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_rd,
    input  logic            flush,
    output logic [AW:0]     pend_cnt
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;
    logic [AW:0]     pend_cnt_q;
    logic [AW:0]     pend_cnt_d;

    logic wr_hit;
    logic iss_hit;
    logic set_new;
    logic clr_old;

    // Register 0 is excluded from both writes and issues; flush suppresses issue.
    assign wr_hit  = wr_en && (wr_addr != '0);
    assign iss_hit = iss_en && (iss_rd != '0) && !flush;

    // Count only real transitions: a set of an already pending bit and a
    // clear overridden by a same-register issue leave the count alone.
    assign set_new = iss_hit && !pend_q[iss_rd];
    assign clr_old = wr_hit && pend_q[wr_addr] && !(iss_hit && (iss_rd == wr_addr));

    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (wr_hit) begin
            regs_d[wr_addr] = wr_data;
            pend_d[wr_addr] = 1'b0;
        end
        if (flush) begin
            pend_d = '0;
        end else if (iss_hit) begin
            pend_d[iss_rd] = 1'b1;
        end
    end

    always_comb begin
        if (flush) begin
            pend_cnt_d = '0;
        end else begin
            pend_cnt_d = pend_cnt_q + (AW+1)'(set_new) - (AW+1)'(clr_old);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    // Returns {ready, data} for one read port.
    function automatic logic [XLEN:0] read_port(
        input logic [AW-1:0]   addr,
        input logic [XLEN-1:0] stored,
        input logic            pend,
        input logic            wen,
        input logic [AW-1:0]   waddr,
        input logic [XLEN-1:0] wdata,
        input logic            rstn
    );
        logic [XLEN:0] r;
        r = {~pend, stored};
        if ((BYPASS != 0) && wen && (waddr == addr)) begin
            r = {1'b1, wdata};
        end
        if ((addr == '0) || !rstn) begin
            r = {1'b1, {XLEN{1'b0}}};
        end
        return r;
    endfunction

    assign {rs1_ready, rs1_data} = read_port(rs1_addr, regs_q[rs1_addr], pend_q[rs1_addr],
                                             wr_en, wr_addr, wr_data, reset_n);
    assign {rs2_ready, rs2_data} = read_port(rs2_addr, regs_q[rs2_addr], pend_q[rs2_addr],
                                             wr_en, wr_addr, wr_data, reset_n);

    assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a forwarding and a non-forwarding instance share
// stimulus and are compared against an array-based reference model.
module tb_regfile_sb;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [AW-1:0]   rs1_addr = '0, rs2_addr = '0, wr_addr = '0, iss_rd = '0;
    logic            wr_en = 1'b0, iss_en = 1'b0, flush = 1'b0;
    logic [XLEN-1:0] wr_data = '0;

    logic [XLEN-1:0] b_rs1_data, b_rs2_data, n_rs1_data, n_rs2_data;
    logic            b_rs1_ready, b_rs2_ready, n_rs1_ready, n_rs2_ready;
    logic [AW:0]     b_pend_cnt, n_pend_cnt;

    int tests = 0;
    int fails = 0;

    logic [XLEN-1:0] mreg  [NREG];
    bit              mpend [NREG];

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
        .rs1_ready(b_rs1_ready), .rs2_ready(b_rs2_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush),
        .pend_cnt(b_pend_cnt)
    );

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0)) dut_n (
        .clk(clk), .reset_n(reset_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(n_rs1_data), .rs2_data(n_rs2_data),
        .rs1_ready(n_rs1_ready), .rs2_ready(n_rs2_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush),
        .pend_cnt(n_pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int popcnt();
        int c = 0;
        for (int i = 0; i < NREG; i++) c += int'(mpend[i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            mreg[i]  = '0;
            mpend[i] = 1'b0;
        end
    endtask

    task automatic exp_read(input logic [AW-1:0] a, input bit byp,
                            output logic [XLEN-1:0] d, output logic r);
        if (!reset_n || a == 0) begin
            d = '0; r = 1'b1;
        end else if (byp && wr_en && wr_addr == a) begin
            d = wr_data; r = 1'b1;
        end else begin
            d = mreg[a]; r = !mpend[a];
        end
    endtask

    task automatic check_all();
        logic [XLEN-1:0] d;
        logic r;
        exp_read(rs1_addr, 1'b1, d, r);
        chk("b_rs1_data", b_rs1_data, d);  chk("b_rs1_ready", b_rs1_ready, r);
        exp_read(rs2_addr, 1'b1, d, r);
        chk("b_rs2_data", b_rs2_data, d);  chk("b_rs2_ready", b_rs2_ready, r);
        exp_read(rs1_addr, 1'b0, d, r);
        chk("n_rs1_data", n_rs1_data, d);  chk("n_rs1_ready", n_rs1_ready, r);
        exp_read(rs2_addr, 1'b0, d, r);
        chk("n_rs2_data", n_rs2_data, d);  chk("n_rs2_ready", n_rs2_ready, r);
        chk("b_pend_cnt", b_pend_cnt, popcnt());
        chk("n_pend_cnt", n_pend_cnt, popcnt());
    endtask

    // Check outputs for the current inputs, then advance one clock and the model.
    task automatic tick();
        logic [XLEN-1:0] nreg  [NREG];
        bit              npend [NREG];
        #1;
        check_all();
        nreg  = mreg;
        npend = mpend;
        if (wr_en && wr_addr != 0) begin
            nreg[wr_addr]  = wr_data;
            npend[wr_addr] = 1'b0;
        end
        if (flush) begin
            for (int i = 0; i < NREG; i++) npend[i] = 1'b0;
        end else if (iss_en && iss_rd != 0) begin
            npend[iss_rd] = 1'b1;
        end
        @(posedge clk);
        if (reset_n) begin
            mreg  = nreg;
            mpend = npend;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        check_all();
        chk("rst_pend_cnt", b_pend_cnt, 0);
        // Write attempt during reset must neither forward nor be captured.
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFE0001; rs1_addr = 5'd3;
        #1;
        chk("rst_no_bypass", b_rs1_data, 0);
        chk("rst_ready", b_rs1_ready, 1);
        @(negedge clk);
        idle();
        reset_n = 1'b1;

        // Write reg5, read it back next cycle; write to reg0 is ignored.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rs1_addr = 5'd5;
        tick();
        idle(); rs1_addr = 5'd5;
        #1;
        chk("r5_data", b_rs1_data, 32'hDEADBEEF);
        chk("r5_ready", b_rs1_ready, 1);
        tick();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rs1_addr = 5'd0;
        tick();
        idle();
        #1;
        chk("r0_data", b_rs1_data, 0);
        chk("r0_data_nb", n_rs1_data, 0);
        tick();

        // Issue to 7, then write back 7 with forwarding.
        iss_en = 1'b1; iss_rd = 5'd7;
        tick();
        idle(); rs2_addr = 5'd7;
        #1;
        chk("r7_pending", b_rs2_ready, 0);
        chk("r7_cnt", b_pend_cnt, 1);
        tick();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12;
        #1;
        chk("r7_fwd_data", b_rs2_data, 32'h12);
        chk("r7_fwd_ready", b_rs2_ready, 1);
        chk("r7_nofwd_ready", n_rs2_ready, 0);
        tick();
        idle();
        #1;
        chk("r7_cnt_clr", b_pend_cnt, 0);
        tick();

        // Same-cycle issue and writeback to reg3: set wins.
        iss_en = 1'b1; iss_rd = 5'd3; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5;
        tick();
        idle(); rs1_addr = 5'd3;
        #1;
        chk("r3_data", b_rs1_data, 32'hA5);
        chk("r3_pending", b_rs1_ready, 0);
        chk("r3_cnt", b_pend_cnt, 1);
        tick();

        // Issue 1,2,3 then WAW to 2; flush beats a same-cycle issue.
        for (int k = 1; k <= 3; k++) begin
            iss_en = 1'b1; iss_rd = AW'(k);
            tick();
        end
        iss_en = 1'b1; iss_rd = 5'd2;
        tick();
        idle();
        #1;
        chk("waw_cnt", b_pend_cnt, 3);
        flush = 1'b1; iss_en = 1'b1; iss_rd = 5'd4;
        tick();
        idle();
        #1;
        chk("flush_cnt", b_pend_cnt, 0);
        for (int a = 0; a < NREG; a++) begin
            rs1_addr = AW'(a);
            #1;
            chk("flush_ready", b_rs1_ready, 1);
        end
        tick();

        // Non-forwarding instance returns old value/status in the write cycle.
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h33;
        tick();
        idle(); iss_en = 1'b1; iss_rd = 5'd9;
        tick();
        idle(); wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55; rs1_addr = 5'd9;
        #1;
        chk("nb_old_data", n_rs1_data, 32'h33);
        chk("nb_old_ready", n_rs1_ready, 0);
        chk("b_new_data", b_rs1_data, 32'h55);
        tick();
        idle();
        #1;
        chk("nb_new_data", n_rs1_data, 32'h55);
        chk("nb_new_ready", n_rs1_ready, 1);
        tick();

        // Random traffic, addresses biased to a small window for collisions.
        for (int n = 0; n < 400; n++) begin
            wr_en    = 1'($urandom_range(0, 1));
            iss_en   = 1'($urandom_range(0, 1));
            flush    = ($urandom_range(0, 15) == 0);
            wr_data  = $urandom;
            wr_addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            iss_rd   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            rs1_addr = ($urandom_range(0, 1) == 0) ? wr_addr : AW'($urandom_range(0, 7));
            rs2_addr = ($urandom_range(0, 1) == 0) ? iss_rd  : AW'($urandom_range(0, 7));
            tick();
        end

        // Asynchronous reset mid-cycle with two pending registers.
        idle(); flush = 1'b1;
        tick();
        idle(); iss_en = 1'b1; iss_rd = 5'd10;
        tick();
        iss_rd = 5'd11;
        tick();
        idle(); rs2_addr = 5'd10;
        #1;
        chk("pre_rst_cnt", b_pend_cnt, 2);
        #1;
        reset_n = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h77; rs1_addr = 5'd5;
        #1;
        model_reset();
        chk("async_cnt", b_pend_cnt, 0);
        chk("async_rs1_data", b_rs1_data, 0);
        chk("async_rs2_ready", b_rs2_ready, 1);
        check_all();
        tick();
        idle();
        reset_n = 1'b1;
        #1;
        chk("post_rst_r5", b_rs1_data, 0);
        tick();
        for (int n = 0; n < 40; n++) begin
            wr_en    = 1'($urandom_range(0, 1));
            iss_en   = 1'($urandom_range(0, 1));
            flush    = ($urandom_range(0, 15) == 0);
            wr_data  = $urandom;
            wr_addr  = AW'($urandom);
            iss_rd   = AW'($urandom);
            rs1_addr = AW'($urandom);
            rs2_addr = wr_addr;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
